// File: rtl/sfifo_pu_queue_mc_pkg.sv
// Shared types for the multi-channel PU queue buffer.
// Payload type and channel index type live in meta_package for the rest of the PU.
package meta_package;

  typedef logic [7:0] pu_queue_payload_type;

  localparam int unsigned MC_CH_NBITS = 2;
  typedef logic [MC_CH_NBITS-1:0] mc_ch_idx_t;

endpackage

// File: rtl/sfifo_pu_queue_mc_ch.sv
// Per-channel controller: pointers, occupancy, status flags and head/RAM path select.
// Occupancy counts the head register plus the RAM entries behind it.
module pu_queue_mc_ch_ctrl #(
  parameter int unsigned DEPTH_NBITS = 3,
  parameter int unsigned AFULL_TH    = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr,
  input  logic                   i_rd,
  input  logic                   i_flush,
  output logic                   o_head_load,
  output logic                   o_ram_load,
  output logic                   o_ram_we,
  output logic                   o_ovf,
  output logic                   o_udf,
  output logic [DEPTH_NBITS-1:0] o_wptr,
  output logic [DEPTH_NBITS-1:0] o_rptr,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_afull,
  output logic [DEPTH_NBITS:0]   o_count
);

  localparam logic [DEPTH_NBITS:0] CapFull = (DEPTH_NBITS+1)'((2 ** DEPTH_NBITS) + 1);
  localparam logic [DEPTH_NBITS:0] AfullTh = (DEPTH_NBITS+1)'(AFULL_TH);

  logic [DEPTH_NBITS-1:0] r_wptr, r_rptr;
  logic [DEPTH_NBITS:0]   r_count, w_count_d;
  logic                   r_empty, r_full, r_afull, r_ram_empty;
  logic                   w_wr, w_rd, w_wr_acc, w_rd_acc, w_head_wr;

  // Flush wins over any op aimed at this channel, silently.
  assign w_wr      = i_wr & ~i_flush;
  assign w_rd      = i_rd & ~i_flush;
  assign w_rd_acc  = w_rd & ~r_empty;
  assign w_wr_acc  = w_wr & (~r_full | w_rd_acc);
  assign w_head_wr = w_wr_acc & (r_empty | (w_rd_acc & r_ram_empty));

  assign o_head_load = w_head_wr;
  assign o_ram_we    = w_wr_acc & ~w_head_wr;
  assign o_ram_load  = w_rd_acc & ~r_ram_empty;
  assign o_ovf       = w_wr & r_full & ~w_rd_acc;
  assign o_udf       = w_rd & r_empty;

  always_comb begin
    w_count_d = r_count + {{DEPTH_NBITS{1'b0}}, w_wr_acc} - {{DEPTH_NBITS{1'b0}}, w_rd_acc};
    if (i_flush) w_count_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
      r_ram_empty <= 1'b1;
    end else begin
      if (o_ram_we)   r_wptr <= r_wptr + 1'b1;
      if (o_ram_load) r_rptr <= r_rptr + 1'b1;
      r_count     <= w_count_d;
      r_empty     <= (w_count_d == '0);
      r_full      <= (w_count_d == CapFull);
      r_afull     <= (w_count_d >= AfullTh);
      r_ram_empty <= (w_count_d <= (DEPTH_NBITS+1)'(1));
    end
  end

  assign o_wptr  = r_wptr;
  assign o_rptr  = r_rptr;
  assign o_count = r_count;
  assign o_empty = r_empty;
  assign o_full  = r_full;
  assign o_afull = r_afull;

endmodule

// File: rtl/sfifo_pu_queue_mc.sv
// Multi-channel synchronous FIFO: NUM_CH queues sharing one RAM, each with a registered head.
// Top holds the shared RAM, head registers, channel decode and error pulses.
module sfifo_pu_queue_mc
  import meta_package::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_NBITS    = 2,
  parameter int unsigned DEPTH_NBITS = 3,
  parameter int unsigned AFULL_TH    = 6
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_wr,
  input  logic [CH_NBITS-1:0]                  i_wr_ch,
  input  pu_queue_payload_type                 i_din,
  input  logic                                 i_rd,
  input  logic [CH_NBITS-1:0]                  i_rd_ch,
  input  logic                                 i_flush,
  input  logic [CH_NBITS-1:0]                  i_flush_ch,
  output pu_queue_payload_type [NUM_CH-1:0]    o_dout,
  output logic [NUM_CH-1:0]                    o_empty,
  output logic [NUM_CH-1:0]                    o_full,
  output logic [NUM_CH-1:0]                    o_afull,
  output logic [NUM_CH-1:0][DEPTH_NBITS:0]     o_count,
  output logic                                 o_ovf_err,
  output logic                                 o_udf_err
);

  localparam int unsigned DEPTH = 2 ** DEPTH_NBITS;
  localparam int unsigned AW    = CH_NBITS + DEPTH_NBITS;

  pu_queue_payload_type r_ram [NUM_CH*DEPTH];
  pu_queue_payload_type [NUM_CH-1:0] r_dout;
  pu_queue_payload_type              w_ram_rdata;

  logic [NUM_CH-1:0] w_wr_vec, w_rd_vec, w_fl_vec;
  logic [NUM_CH-1:0] w_head_load, w_ram_load, w_ram_we, w_ovf, w_udf;
  logic [NUM_CH-1:0][DEPTH_NBITS-1:0] w_wptr, w_rptr;
  logic [DEPTH_NBITS-1:0] w_wr_ptr, w_rd_ptr;
  logic [AW-1:0]          w_wr_addr, w_rd_addr;
  logic                   r_ovf, r_udf;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Out-of-range channel indices match no channel and are dropped.
    assign w_wr_vec[c] = i_wr    & (i_wr_ch    == CH_NBITS'(c));
    assign w_rd_vec[c] = i_rd    & (i_rd_ch    == CH_NBITS'(c));
    assign w_fl_vec[c] = i_flush & (i_flush_ch == CH_NBITS'(c));

    pu_queue_mc_ch_ctrl #(
      .DEPTH_NBITS (DEPTH_NBITS),
      .AFULL_TH    (AFULL_TH)
    ) u_ch_ctrl (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_wr        (w_wr_vec[c]),
      .i_rd        (w_rd_vec[c]),
      .i_flush     (w_fl_vec[c]),
      .o_head_load (w_head_load[c]),
      .o_ram_load  (w_ram_load[c]),
      .o_ram_we    (w_ram_we[c]),
      .o_ovf       (w_ovf[c]),
      .o_udf       (w_udf[c]),
      .o_wptr      (w_wptr[c]),
      .o_rptr      (w_rptr[c]),
      .o_empty     (o_empty[c]),
      .o_full      (o_full[c]),
      .o_afull     (o_afull[c]),
      .o_count     (o_count[c])
    );

    always_ff @(posedge i_clk) begin
      if (w_head_load[c])     r_dout[c] <= i_din;
      else if (w_ram_load[c]) r_dout[c] <= w_ram_rdata;
    end
  end

  always_comb begin
    w_wr_ptr = '0;
    w_rd_ptr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_wr_vec[c]) w_wr_ptr = w_wptr[c];
      if (w_rd_vec[c]) w_rd_ptr = w_rptr[c];
    end
  end

  assign w_wr_addr   = {i_wr_ch, w_wr_ptr};
  assign w_rd_addr   = {i_rd_ch, w_rd_ptr};
  // Read-before-write: a full channel doing wr+rd on the same slot pops the old word.
  assign w_ram_rdata = r_ram[w_rd_addr];

  always_ff @(posedge i_clk) begin
    if (!i_rst && (|w_ram_we)) r_ram[w_wr_addr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= |w_ovf;
      r_udf <= |w_udf;
    end
  end

  assign o_dout    = r_dout;
  assign o_ovf_err = r_ovf;
  assign o_udf_err = r_udf;

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (!i_rst) begin
      if (|w_ovf) $display("sfifo_pu_queue_mc: write to full channel %0d dropped", i_wr_ch);
      if (|w_udf) $display("sfifo_pu_queue_mc: read of empty channel %0d ignored", i_rd_ch);
      if (i_wr && (32'(i_wr_ch) >= NUM_CH))
        $display("sfifo_pu_queue_mc: write channel %0d out of range", i_wr_ch);
      if (i_rd && (32'(i_rd_ch) >= NUM_CH))
        $display("sfifo_pu_queue_mc: read channel %0d out of range", i_rd_ch);
      if (i_flush && (32'(i_flush_ch) >= NUM_CH))
        $display("sfifo_pu_queue_mc: flush channel %0d out of range", i_flush_ch);
    end
  end
`endif

endmodule

// File: tb/tb_sfifo_pu_queue_mc.sv
// Scoreboard bench for sfifo_pu_queue_mc: stimulus queues expected state, monitor checks it.
module tb_sfifo_pu_queue_mc;
  import meta_package::*;

  localparam int SelDout = 0, SelEmpty = 1, SelFull = 2, SelAfull = 3;
  localparam int SelCount = 4, SelOvf = 5, SelUdf = 6;

  logic clk = 1'b0;
  logic rst = 1'b1, wr = 1'b0, rd = 1'b0, fl = 1'b0;
  mc_ch_idx_t wch = '0, rch = '0, fch = '0;
  pu_queue_payload_type din = '0;

  pu_queue_payload_type [3:0] dout;
  logic [3:0]             empty, full, afull;
  logic [3:0][3:0]        count;
  logic                   ovf, udf;

  sfifo_pu_queue_mc #(
    .NUM_CH      (4),
    .CH_NBITS    (2),
    .DEPTH_NBITS (3),
    .AFULL_TH    (6)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr       (wr),
    .i_wr_ch    (wch),
    .i_din      (din),
    .i_rd       (rd),
    .i_rd_ch    (rch),
    .i_flush    (fl),
    .i_flush_ch (fch),
    .o_dout     (dout),
    .o_empty    (empty),
    .o_full     (full),
    .o_afull    (afull),
    .o_count    (count),
    .o_ovf_err  (ovf),
    .o_udf_err  (udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    tag;
    int    sel;
    int    ch;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic int actual(input int sel, input int ch);
    case (sel)
      SelDout:  return int'(dout[ch]);
      SelEmpty: return int'(empty);
      SelFull:  return int'(full);
      SelAfull: return int'(afull);
      SelCount: return int'(count[ch]);
      SelOvf:   return int'(ovf);
      default:  return int'(udf);
    endcase
  endfunction

  // Monitor: after each edge, compare every expectation tagged for this cycle.
  exp_t mon_e;
  int   mon_a;
  always @(posedge clk) begin
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      mon_e = sb.pop_front();
      mon_a = actual(mon_e.sel, mon_e.ch);
      n_chk++;
      if (mon_e.tag != cyc || mon_a != mon_e.val) begin
        n_fail++;
        $display("FAIL %s (ch %0d, cycle %0d): got 0x%0h, expected 0x%0h",
                 mon_e.name, mon_e.ch, cyc, mon_a, mon_e.val);
      end
    end
  end

  task automatic op(input bit r, input bit w, input int wc, input int d,
                    input bit rr, input int rc, input bit f, input int fc);
    @(negedge clk);
    rst = r;
    wr  = w;
    wch = mc_ch_idx_t'(wc);
    din = pu_queue_payload_type'(d);
    rd  = rr;
    rch = mc_ch_idx_t'(rc);
    fl  = f;
    fch = mc_ch_idx_t'(fc);
  endtask

  task automatic idle();
    op(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_wr(input int c, input int d);
    op(0, 1, c, d, 0, 0, 0, 0);
  endtask

  task automatic pop(input int c);
    op(0, 0, 0, 0, 1, c, 0, 0);
  endtask

  // Expectation for the state right after the edge that samples the op just driven.
  task automatic expect_v(input int sel, input int ch, input int val, input string nm);
    sb.push_back('{cyc + 1, sel, ch, val, nm});
  endtask

  initial begin
    // Reset
    op(1, 0, 0, 0, 0, 0, 0, 0);
    op(1, 0, 0, 0, 0, 0, 0, 0);
    expect_v(SelEmpty, 0, 'hF, "reset_empty");
    expect_v(SelFull, 0, 0, "reset_full");
    expect_v(SelAfull, 0, 0, "reset_afull");
    expect_v(SelOvf, 0, 0, "reset_ovf");
    expect_v(SelUdf, 0, 0, "reset_udf");
    for (int c = 0; c < 4; c++) expect_v(SelCount, c, 0, "reset_count");

    // Single write to ch2 lands in the head register
    push_wr(2, 'hA1);
    expect_v(SelDout, 2, 'hA1, "wr_head_dout");
    expect_v(SelEmpty, 0, 'hB, "wr_head_empty");
    expect_v(SelCount, 2, 1, "wr_head_count");

    // Fill ch1 to capacity 9
    for (int k = 1; k <= 9; k++) begin
      push_wr(1, 'h10 + k - 1);
      expect_v(SelCount, 1, k, "fill_count");
      expect_v(SelAfull, 0, (k >= 6) ? 'h2 : 'h0, "fill_afull");
      expect_v(SelFull, 0, (k == 9) ? 'h2 : 'h0, "fill_full");
      if (k == 1) expect_v(SelDout, 1, 'h10, "fill_first_dout");
    end
    push_wr(1, 'h19);
    expect_v(SelOvf, 0, 1, "ovf_pulse");
    expect_v(SelCount, 1, 9, "ovf_count");
    expect_v(SelDout, 1, 'h10, "ovf_dout");
    idle();
    expect_v(SelOvf, 0, 0, "ovf_clear");

    // Drain ch1 in order
    for (int i = 0; i < 9; i++) begin
      pop(1);
      expect_v(SelCount, 1, 8 - i, "drain_count");
      expect_v(SelAfull, 0, ((8 - i) >= 6) ? 'h2 : 'h0, "drain_afull");
      expect_v(SelUdf, 0, 0, "drain_udf");
      if (i < 8) expect_v(SelDout, 1, 'h11 + i, "drain_dout");
    end
    expect_v(SelEmpty, 0, 'hB, "drain_empty");

    // Head-path simultaneous rd+wr on a one-entry channel
    push_wr(0, 'h55);
    expect_v(SelDout, 0, 'h55, "ch0_first");
    op(0, 1, 0, 'h66, 1, 0, 0, 0);
    expect_v(SelDout, 0, 'h66, "rdwr_head_dout");
    expect_v(SelCount, 0, 1, "rdwr_head_count");
    expect_v(SelEmpty, 0, 'hA, "rdwr_head_empty");

    // Fill ch0, then cross-channel write+pop
    for (int j = 0; j < 8; j++) push_wr(0, 'h80 + j);
    expect_v(SelCount, 0, 9, "ch0_full_count");
    expect_v(SelFull, 0, 'h1, "ch0_full_flag");
    op(0, 1, 3, 'h77, 1, 0, 0, 0);
    expect_v(SelDout, 3, 'h77, "xch_dout3");
    expect_v(SelCount, 0, 8, "xch_count0");
    expect_v(SelCount, 3, 1, "xch_count3");
    expect_v(SelDout, 0, 'h80, "xch_dout0");
    expect_v(SelOvf, 0, 0, "xch_ovf");
    expect_v(SelUdf, 0, 0, "xch_udf");
    expect_v(SelFull, 0, 0, "xch_full");

    // Same-channel wr+rd on a full channel: legal, count unchanged
    push_wr(0, 'h88);
    expect_v(SelFull, 0, 'h1, "refill_full");
    op(0, 1, 0, 'h89, 1, 0, 0, 0);
    expect_v(SelCount, 0, 9, "fullrw_count");
    expect_v(SelOvf, 0, 0, "fullrw_ovf");
    expect_v(SelDout, 0, 'h81, "fullrw_dout");
    expect_v(SelFull, 0, 'h1, "fullrw_full");
    pop(0);
    expect_v(SelDout, 0, 'h82, "fullrw_next_dout");
    expect_v(SelCount, 0, 8, "fullrw_next_count");

    // Flush priority over same-channel write; other channel proceeds
    for (int j = 0; j < 4; j++) push_wr(1, 'h41 + j);
    expect_v(SelCount, 1, 4, "preflush_count1");
    push_wr(2, 'hA2);
    expect_v(SelCount, 2, 2, "preflush_count2");
    op(0, 1, 1, 'h99, 1, 2, 1, 1);
    expect_v(SelCount, 1, 0, "flush_count1");
    expect_v(SelEmpty, 0, 'h2, "flush_empty");
    expect_v(SelOvf, 0, 0, "flush_ovf");
    expect_v(SelUdf, 0, 0, "flush_udf");
    expect_v(SelCount, 2, 1, "flush_count2");
    expect_v(SelDout, 2, 'hA2, "flush_dout2");
    pop(1);
    expect_v(SelUdf, 0, 1, "postflush_udf");

    // Reset mid-fill discards contents and the op in the reset cycle
    op(0, 0, 0, 0, 0, 0, 1, 0);
    expect_v(SelCount, 0, 0, "flush0_count");
    expect_v(SelUdf, 0, 0, "flush0_udf");
    for (int j = 0; j < 5; j++) push_wr(0, 'hC0 + j);
    expect_v(SelCount, 0, 5, "midfill_count");
    op(1, 1, 0, 'hC5, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) expect_v(SelCount, c, 0, "rst_mid_count");
    expect_v(SelEmpty, 0, 'hF, "rst_mid_empty");
    expect_v(SelFull, 0, 0, "rst_mid_full");
    expect_v(SelOvf, 0, 0, "rst_mid_ovf");
    pop(0);
    expect_v(SelUdf, 0, 1, "rst_udf");
    expect_v(SelCount, 0, 0, "rst_udf_count");
    idle();
    expect_v(SelUdf, 0, 0, "udf_clear");

    // Let the monitor drain the scoreboard, bounded
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      n_fail += sb.size();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sfifo_pu_queue_mc.md
Name: sfifo_pu_queue_mc

Overview:
Multi-channel synchronous FIFO for pu_queue_payload_type entries. NUM_CH logical queues share one storage array. Each queue presents a registered head word, so dout[ch] is valid whenever empty[ch]=0. It is the next-generation PU queue buffer, adding:
- per-channel addressing
- almost-full thresholds
- per-channel flush
- overflow/underflow error flags

Parameters:
NUM_CH, 4, number of logical queues
CH_NBITS, 2, width of channel index; NUM_CH <= 2**CH_NBITS
DEPTH_NBITS, 3, log2 of per-channel storage entries; DEPTH = 2**DEPTH_NBITS
AFULL_TH, 6, per-channel count at or above which afull[ch] asserts; range 1..DEPTH+1

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
wr  in  1  write strobe
wr_ch  in  CH_NBITS  target channel of write
din  in  pu_queue_payload_type  write data
rd  in  1  read (pop) strobe
rd_ch  in  CH_NBITS  channel popped
flush  in  1  flush strobe
flush_ch  in  CH_NBITS  channel flushed
dout  out  pu_queue_payload_type [NUM_CH]  registered head word per channel
empty  out  NUM_CH  per-channel empty, registered
full  out  NUM_CH  count[ch]==DEPTH+1, registered
afull  out  NUM_CH  count[ch]>=AFULL_TH, registered
count  out  (DEPTH_NBITS+1) x NUM_CH  per-channel occupancy
ovf_err  out  1  one-cycle pulse: write to full channel dropped
udf_err  out  1  one-cycle pulse: read of empty channel ignored

Behaviour:
Capacity and storage
- Per-channel capacity = DEPTH+1: the head register plus DEPTH RAM entries.
- RAM is NUM_CH*DEPTH entries, addressed {ch, ptr}, with one write port and one read port.
- Each channel has rptr/wptr (DEPTH_NBITS bits, natural wrap), a ram_empty flag and a count.

Reset (rst=1 at posedge)
- All counts and pointers are 0; empty=all 1s; full=0; afull=0; ovf_err=0; udf_err=0.
- dout and RAM contents are don't-care (not reset).
- Reset mid-operation discards all contents; ops asserted in the reset cycle are ignored.

Write (wr to ch)
- Head path: if empty[ch], or (rd to ch this cycle and ram_empty[ch]), then dout[ch] <= din at the next edge. RAM is untouched.
- RAM path: otherwise RAM[{ch,wptr}] <= din and wptr++.
- Visibility: data written in cycle N is visible on dout in cycle N+1 at the earliest (1-cycle latency).

Read (rd to ch, pops the head)
- If ram_empty[ch]=0: dout[ch] <= RAM[{ch,rptr}] and rptr++.
- Else if a same-cycle write to the same channel takes the head path: dout[ch] <= din.
- Else: empty[ch] <= 1 and dout[ch] holds its value.
- Same-channel wr+rd on a full channel is legal: count is unchanged and no ovf_err.

Count update
- count[ch] += (accepted wr) − (accepted rd), evaluated per channel.
- Writes and reads to different channels in the same cycle are independent.
- full, afull and empty are registered and derived from the next-state count.

Errors
- wr to a full channel with no same-cycle rd of that channel: write dropped, ovf_err=1 for one cycle.
- rd to an empty channel: ignored, udf_err=1 for one cycle.
- Simulation-only $display on both conditions.

Flush (flush to ch)
- Next cycle: count[ch]=0, pointers 0, empty[ch]=1.
- Flush has priority: wr and rd targeting flush_ch in the same cycle are dropped, with no error pulse.
- Ops to other channels in the flush cycle proceed normally.

Index range
- wr_ch, rd_ch or flush_ch >= NUM_CH: the op is ignored; simulation $display.

Decomposition:
- pu_queue_payload_type stays in meta_package.
- Add mc_ch_idx_t (CH_NBITS) to meta_package.
- Sub-module pu_queue_mc_ch_ctrl, instantiated once per channel. It owns:
  - pointers, count and ram_empty
  - empty/full/afull
  - head-path / RAM-path select
- The top level holds the shared RAM, the dout registers, channel decode, and error pulse generation.

Test Plan:
- Reset, then wr ch2 D=0xA1: next cycle dout[2]=0xA1, empty=4'b1011, count[2]=1; RAM untouched.
- Fill ch1 with 9 writes 0x10..0x18: full[1]=1, afull[1] asserts after the 6th write, count[1]=9. A 10th write gives ovf_err pulse and count stays 9. Nine pops return 0x10..0x18 in order, then empty[1]=1.
- Head-path simultaneous op: ch0 holds 1 entry (0x55), same cycle rd ch0 + wr ch0 D=0x66: next cycle dout[0]=0x66, count[0]=1, empty[0]=0.
- Cross-channel op: ch0 full, same cycle wr ch3 D=0x77 + rd ch0: dout[3]=0x77, count[0]=8, count[3]=1, no errors.
- Flush priority: ch1 count=4, same cycle flush ch1 + wr ch1 + wr... → instead issue flush ch1 + wr ch1 + rd ch2 (ch2 holds 2 entries): count[1]=0, empty[1]=1, no ovf_err/udf_err; ch2 count=1.
- Reset mid-fill (ch0 count=5, rst with wr ch0 asserted): next cycle all counts 0, empty=4'b1111. rd ch0 after reset gives udf_err=1.
